// File: rtl/wrr_pkt_arbiter.sv
// N-way weighted round-robin arbiter with packet locking and a registered one-hot grant.
// Optional grant watchdog is enabled by defining WRR_ARB_TIMEOUT_EN.
module wrr_pkt_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  ack,
  input  logic                  last,
  output logic [N-1:0]          gnt,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output logic                  any_gnt,
  output logic                  timeout_err
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state;
  logic [IW-1:0]       pri;
  logic [WEIGHT_W-1:0] credit;

  logic [IW-1:0]       nxt_pri;
  logic [IW-1:0]       base;
  logic [IW-1:0]       sel;
  logic                found;
  logic [N-1:0]        sel_onehot;
  logic [WEIGHT_W-1:0] w_sel;
  logic [WEIGHT_W-1:0] load_credit;
  logic                timeout_hit;
  logic                pkt_end;
  logic                extend;

  // Priority pointer after the current owner; a release searches from here so no bubble is needed.
  always_comb begin
    if (gnt_idx == IW'(N - 1)) begin
      nxt_pri = '0;
    end else begin
      nxt_pri = gnt_idx + IW'(1);
    end
    if (state == GRANT) begin
      base = nxt_pri;
    end else begin
      base = pri;
    end
  end

  // Rotating first-set search; iterating downwards lets the nearest port to base win.
  always_comb begin
    int p;
    found = 1'b0;
    sel   = '0;
    p     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(base) + k) % N;
      if (req[p]) begin
        found = 1'b1;
        sel   = IW'(p);
      end else begin
        found = found;
      end
    end
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  // Credit for a fresh turn: a zero weight still allows one packet.
  always_comb begin
    w_sel = weight[int'(sel)*WEIGHT_W +: WEIGHT_W];
    if (w_sel == '0) begin
      load_credit = '0;
    end else begin
      load_credit = w_sel - WEIGHT_W'(1);
    end
  end

`ifdef WRR_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wd;

  always_comb begin
    timeout_hit = (state == GRANT) && !ack && (wd == TW'(TIMEOUT - 1));
  end

  // Watchdog: counts ack-less grant cycles; the pulse lands with the forced release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != GRANT || ack || timeout_hit) begin
        wd <= '0;
      end else begin
        wd <= wd + TW'(1);
      end
    end
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end

  assign timeout_err = 1'b0;
`endif

  always_comb begin
    pkt_end = (ack & last) | timeout_hit;
    extend  = ack & last & (credit != '0) & req[gnt_idx] & en & ~timeout_hit;
  end

  // Arbitration FSM; grant outputs are registered and only change at packet boundaries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pri     <= '0;
      credit  <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      any_gnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            state   <= GRANT;
            gnt     <= sel_onehot;
            gnt_idx <= sel;
            any_gnt <= 1'b1;
            credit  <= load_credit;
          end
        end
        GRANT: begin
          if (!pkt_end) begin
            state <= GRANT;
          end else if (extend) begin
            credit <= credit - WEIGHT_W'(1);
          end else begin
            pri <= nxt_pri;
            if (en && found) begin
              gnt     <= sel_onehot;
              gnt_idx <= sel;
              credit  <= load_credit;
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_idx <= '0;
              any_gnt <= 1'b0;
              credit  <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          gnt_idx <= '0;
          any_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Self-checking bench for wrr_pkt_arbiter: directed scenarios plus random traffic
// compared against an integer-level model of the arbitration rules.
module tb_wrr_pkt_arbiter;
  localparam int N      = 4;
  localparam int WW     = 4;
  localparam int TO_CYC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*WW-1:0] weight = '0;
  logic          ack = 1'b0;
  logic          last = 1'b0;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_idx;
  logic          any_gnt;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  // model state: owner port (-1 when nobody holds the bus), credits left, pointer, watchdog
  int m_own = -1;
  int m_cred = 0;
  int m_pri = 0;
  int m_wd = 0;
  bit m_to = 1'b0;

  wrr_pkt_arbiter #(.N(N), .WEIGHT_W(WW), .TIMEOUT(TO_CYC)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .weight(weight),
    .ack(ack), .last(last), .gnt(gnt), .gnt_idx(gnt_idx),
    .any_gnt(any_gnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int turn_len(input int p);
    int w;
    w = int'(weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_edge(input logic r_n, input logic e, input logic [N-1:0] rq,
                            input logic a, input logic l);
    bit to_now;
    bit done;
    int p;
    m_to = 1'b0;
    if (!r_n) begin
      m_own = -1; m_cred = 0; m_pri = 0; m_wd = 0;
    end else if (m_own < 0) begin
      m_wd = 0;
      p = pick(rq, m_pri);
      if (e && p >= 0) begin
        m_own = p; m_cred = turn_len(p) - 1;
      end
    end else begin
`ifdef WRR_ARB_TIMEOUT_EN
      to_now = !a && (m_wd == TO_CYC - 1);
`else
      to_now = 1'b0;
`endif
      done = (a && l) || to_now;
      if (!done) begin
        m_wd = a ? 0 : m_wd + 1;
      end else if (!to_now && m_cred > 0 && rq[m_own] && e) begin
        m_cred--; m_wd = 0;
      end else begin
        m_pri = (m_own + 1) % N;
        m_to = to_now;
        m_wd = 0;
        p = pick(rq, m_pri);
        if (e && p >= 0) begin
          m_own = p; m_cred = turn_len(p) - 1;
        end else begin
          m_own = -1; m_cred = 0;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic r_n, input logic e, input logic [N-1:0] rq,
                      input logic a, input logic l);
    reset = r_n; en = e; req = rq; ack = a; last = l;
    @(posedge clk);
    model_edge(r_n, e, rq, a, l);
    #1;
    chk("gnt", 32'(gnt), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
    chk("any_gnt", 32'(any_gnt), (m_own >= 0) ? 32'd1 : 32'd0);
    if (m_own >= 0) chk("gnt_idx", 32'(gnt_idx), 32'(m_own));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [N-1:0] exp_rr [5];
    logic [N-1:0] exp_wrr [8];
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_wrr = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};

    // reset holds grant off even with every port requesting
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_any", 32'(any_gnt), 32'd0);
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);

    // plain round robin with single-beat packets
    step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    chk("rr_0", 32'(gnt), 32'(exp_rr[0]));
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
      chk($sformatf("rr_%0d", i), 32'(gnt), 32'(exp_rr[i]));
    end

    // weighted: port0 gets three packets per turn, port2 one
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
    chk("wrr_0", 32'(gnt), 32'(exp_wrr[0]));
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b1, 4'b0101, 1'b1, 1'b1);
      chk($sformatf("wrr_%0d", i), 32'(gnt), 32'(exp_wrr[i]));
    end

    // packet lock: requester drops mid-packet, another requester waits for last
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
    chk("lock_hold", 32'(gnt), 32'b0010);
    step(1'b1, 1'b1, 4'b1000, 1'b1, 1'b1);
    chk("lock_next", 32'(gnt), 32'b1000);

    // disable mid-packet: packet finishes despite spare credit, then no grants
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
    chk("en_hold", 32'(gnt), 32'b0001);
    step(1'b1, 1'b0, 4'b0001, 1'b1, 1'b1);
    chk("en_release", 32'(gnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'b1111, 1'b1, 1'b1);
      chk("en_block", 32'(any_gnt), 32'd0);
    end

`ifdef WRR_ARB_TIMEOUT_EN
    // stalled owner is forced off after TO_CYC ack-less cycles
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < TO_CYC - 1; i++) begin
      step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0);
      chk("to_wait", 32'(timeout_err), 32'd0);
    end
    step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_next", 32'(gnt), 32'b1000);
    step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0);
    chk("to_once", 32'(timeout_err), 32'd0);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) weight = N*WW'($urandom);
      step(($urandom_range(99) != 0), ($urandom_range(9) != 0), N'($urandom),
           ($urandom_range(9) < 6), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
